// File: rtl/rf_dump_reader.sv
// rf_dump_reader
//   Walks a two-read-port register file pair by pair and streams every
//   register out as a valid/ready beat (register number + value). It keeps
//   a running modulo-2^32 sum of the accepted beats. Each pair is fetched in
//   one cycle, then emitted as two beats.
//
//   NREG must be even and lie in 2..32.
//
// Ports
//   clk        system clock, rising-edge only
//   rst_n      synchronous active-low reset
//   start      begin a dump (only looked at while idle)
//   rn1, rn2   register-file read addresses (2p and 2p+1)
//   rd1, rd2   register-file read data, combinational from rn1/rn2
//   out_valid  beat present on out_idx/out_data
//   out_ready  downstream accepts the beat
//   out_idx    register number of the beat
//   out_data   register value of the beat
//   busy       high whenever not idle
//   done       one-cycle pulse when the last beat has been accepted
//   sum        running sum of accepted beats; held until the next start
module rf_dump_reader #(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  rn1,
  output logic [4:0]  rn2,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] sum
);

  localparam int DATA_W = 32;
  localparam logic [4:0] LAST_IDX = 5'(NREG - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EMIT0,
    S_EMIT1,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        p_q;
  logic [DATA_W-1:0] b0_p0, b1_p0;
  logic [DATA_W-1:0] sum_q;

  logic clr_run;
  logic cap_pair;
  logic next_pair;
  logic xfer;
  logic last_pair;

  // The sum deliberately wraps: only the low DATA_W bits are kept.
  function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W:0] full;
    full = {1'b0, a} + {1'b0, b};
    return full[DATA_W-1:0];
  endfunction

  // Read addresses follow the pair counter in every state.
  assign rn1 = {p_q, 1'b0};
  assign rn2 = {p_q, 1'b1};

  assign last_pair = ({p_q, 1'b1} == LAST_IDX);
  assign xfer      = out_valid & out_ready;
  assign sum       = sum_q;

  always_comb begin
    state_d   = state_q;
    clr_run   = 1'b0;
    cap_pair  = 1'b0;
    next_pair = 1'b0;
    out_valid = 1'b0;
    out_idx   = 5'd0;
    out_data  = '0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          clr_run = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        cap_pair = 1'b1;
        state_d  = S_EMIT0;
      end
      S_EMIT0: begin
        out_valid = 1'b1;
        out_idx   = {p_q, 1'b0};
        out_data  = b0_p0;
        if (out_ready) state_d = S_EMIT1;
      end
      S_EMIT1: begin
        out_valid = 1'b1;
        out_idx   = {p_q, 1'b1};
        out_data  = b1_p0;
        if (out_ready) begin
          if (last_pair) begin
            state_d = S_DONE;
          end else begin
            next_pair = 1'b1;
            state_d   = S_FETCH;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage p0: pair capture from the register file, plus control state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      p_q     <= 4'd0;
      b0_p0   <= '0;
      b1_p0   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      if (clr_run)        p_q <= 4'd0;
      else if (next_pair) p_q <= p_q + 4'd1;
      if (cap_pair) begin
        b0_p0 <= rd1;
        b1_p0 <= rd2;
      end
      if (clr_run)   sum_q <= '0;
      else if (xfer) sum_q <= wrap_add(sum_q, out_data);
    end
  end

endmodule

// File: tb/tb_rf_dump_reader.sv
module tb_rf_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, out_ready;
  logic [31:0] rf [32];

  logic [4:0]  rn1, rn2, out_idx;
  logic [31:0] rd1, rd2, out_data, sum;
  logic        out_valid, busy, done;

  logic        start4, out_ready4;
  logic [4:0]  rn1_4, rn2_4, out_idx4;
  logic [31:0] rd1_4, rd2_4, out_data4, sum4;
  logic        out_valid4, busy4, done4;

  assign rd1   = rf[rn1];
  assign rd2   = rf[rn2];
  assign rd1_4 = rf[rn1_4];
  assign rd2_4 = rf[rn2_4];

  rf_dump_reader #(.NREG(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rn1(rn1), .rn2(rn2), .rd1(rd1), .rd2(rd2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_data(out_data),
    .busy(busy), .done(done), .sum(sum)
  );

  rf_dump_reader #(.NREG(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .rn1(rn1_4), .rn2(rn2_4), .rd1(rd1_4), .rd2(rd2_4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_idx(out_idx4), .out_data(out_data4),
    .busy(busy4), .done(done4), .sum(sum4)
  );

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];
  beat_t exp4_q[$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int done4_cnt = 0;
  bit rand_rdy = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  // Scoreboard monitors: a beat is taken at the edge following a negedge
  // where valid and ready are both high (and reset is not asserted).
  initial forever begin
    beat_t e;
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat_idx", 32'(out_idx), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("beat_idx", 32'(out_idx), 32'(e.idx));
        chk("beat_data", out_data, e.data);
      end
    end
    if (done) done_cnt++;
  end

  initial forever begin
    beat_t e;
    @(negedge clk);
    if (rst_n && out_valid4 && out_ready4) begin
      if (exp4_q.size() == 0) begin
        chk("unexpected_beat4_idx", 32'(out_idx4), 32'hFFFF_FFFF);
      end else begin
        e = exp4_q.pop_front();
        chk("beat4_idx", 32'(out_idx4), 32'(e.idx));
        chk("beat4_data", out_data4, e.data);
      end
    end
    if (done4) done4_cnt++;
  end

  // Random backpressure, active only when requested.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected stream for one dump: every register in ascending order with
  // the value present now; the reference sum is the plain 32-bit total.
  task automatic push_dump(input int n, input bit to4, output logic [31:0] s);
    beat_t b;
    s = 32'd0;
    for (int i = 0; i < n; i++) begin
      b.idx  = 5'(i);
      b.data = rf[i];
      if (to4) exp4_q.push_back(b);
      else     exp_q.push_back(b);
      s = s + rf[i];
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!done && n < 3000);
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic wait_beat(input logic [4:0] idx);
    int n;
    n = 0;
    while (!(out_valid && out_idx == idx) && n < 500) begin
      step();
      n++;
    end
    chk("beat_presented", 32'(out_idx), 32'(idx));
  endtask

  initial begin
    logic [31:0] s, s4, hold;
    int n, dc0;

    rst_n = 1'b0; start = 1'b0; start4 = 1'b0;
    out_ready = 1'b1; out_ready4 = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    repeat (3) step();

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_rn1", 32'(rn1), 32'd0);
    chk("rst_rn2", 32'(rn2), 32'd1);

    // Squares, full-rate stream; start accepted at first edge out of reset
    for (int i = 0; i < 32; i++) rf[i] = 32'(i * i);
    push_dump(32, 1'b0, s);
    dc0 = done_cnt;
    rst_n = 1'b1;
    pulse_start();
    chk("first_start_busy", 32'(busy), 32'd1);
    wait_done(n);
    chk("dump_cycles", 32'(n), 32'd48);
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
    chk("done_pulses", 32'(done_cnt - dc0), 32'd1);
    chk("squares_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("squares_sum_model", sum, s);
    chk("squares_sum_const", sum, 32'd10416);
    repeat (4) step();
    chk("sum_holds", sum, 32'd10416);

    // Stall for three cycles while idx 5 is presented
    push_dump(32, 1'b0, s);
    pulse_start();
    wait_beat(5'd5);
    hold = sum;
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("stall_idx", 32'(out_idx), 32'd5);
      chk("stall_data", out_data, 32'd25);
      step();
    end
    chk("stall_idx_last", 32'(out_idx), 32'd5);
    chk("stall_data_last", out_data, 32'd25);
    chk("stall_sum_held", sum, hold);
    out_ready = 1'b1;
    wait_done(n);
    step();
    chk("stall_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("stall_sum", sum, s);

    // Reset in the middle of the stream
    push_dump(32, 1'b0, s);
    pulse_start();
    wait_beat(5'd12);
    dc0 = done_cnt;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_sum", sum, 32'd0);
    exp_q.delete();
    repeat (5) step();
    chk("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    push_dump(32, 1'b0, s);
    pulse_start();
    wait_done(n);
    step();
    chk("restart_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("restart_sum", sum, s);

    // start held high: one dump, idle for one cycle, then the next dump
    push_dump(32, 1'b0, s);
    push_dump(32, 1'b0, s);
    dc0 = done_cnt;
    start = 1'b1;
    wait_done(n);
    step();
    chk("held_start_idle", 32'(busy), 32'd0);
    chk("held_start_one_done", 32'(done_cnt - dc0), 32'd1);
    step();
    chk("held_start_restart", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(n);
    step();
    chk("held_start_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("held_start_two_done", 32'(done_cnt - dc0), 32'd2);
    chk("held_start_sum", sum, s);

    // All-ones contents: sum wraps
    for (int i = 0; i < 32; i++) rf[i] = 32'hFFFF_FFFF;
    push_dump(32, 1'b0, s);
    pulse_start();
    wait_done(n);
    step();
    chk("wrap_sum_model", sum, s);
    chk("wrap_sum_const", sum, 32'hFFFF_FFE0);

    // Random contents with random backpressure
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      push_dump(32, 1'b0, s);
      rand_rdy = 1'b1;
      pulse_start();
      wait_done(n);
      rand_rdy = 1'b0;
      step();
      out_ready = 1'b1;
      chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("rand_sum", sum, s);
    end

    // Four-register instance
    push_dump(4, 1'b1, s4);
    dc0 = done4_cnt;
    start4 = 1'b1;
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) start4 = 1'b0;
    end while (!done4 && n < 100);
    chk("nreg4_done_latency", 32'(n), 32'd7);
    step();
    chk("nreg4_queue_empty", 32'(exp4_q.size()), 32'd0);
    chk("nreg4_sum", sum4, s4);
    chk("nreg4_done_pulses", 32'(done4_cnt - dc0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
